// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the serial-port blocks (uart_rx, uart_tx,
// uart_rx_ctrl):
//   - bit_cycles()     : system clocks per line bit (integer division)
//   - timeout_cycles() : idle timeout in system clocks
//   - rx_ctrl_state_t  : state of the receive-side idle-timeout FSM
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // nothing pending, timeout counter parked at 0
      ARMED   = 2'd1,   // data pending, counting idle clocks
      TIMEOUT = 2'd2    // interrupt raised, waiting for new data or a drain
   } rx_ctrl_state_t;

   // System clocks per bit on the line. Truncating division is intentional:
   // the receiver and transmitter must agree on the same rounding.
   function automatic int unsigned bit_cycles(input int unsigned freq_clk,
                                              input int unsigned speed);
      return freq_clk / speed;
   endfunction

   // Idle timeout expressed in system clocks.
   function automatic int unsigned timeout_cycles(input int unsigned freq_clk,
                                                  input int unsigned speed,
                                                  input int unsigned bits);
      return bits * bit_cycles(freq_clk, speed);
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Generic single-clock first-word-fall-through FIFO. The head entry is always
// presented on Rd_Data; Rd_En consumes it.
//
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   Wr_Data    : data to write
//   Wr_En      : write request; accepted when not full, or when a read
//                happens in the same cycle
//   Rd_En      : read request; takes effect only when not empty
//   Rd_Data    : head entry (decoded from registered storage)
//   Count      : number of entries held
//   Full       : Count == DEPTH
//   Empty      : Count == 0
//   Drop       : Wr_En refused this cycle (full and no read)
//
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fifo_sync #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                           Clk,
   input  logic                           Rst_n,
   input  logic [DATA_W-1:0]              Wr_Data,
   input  logic                           Wr_En,
   input  logic                           Rd_En,
   output logic [DATA_W-1:0]              Rd_Data,
   output logic [$clog2(DEPTH+1)-1:0]     Count,
   output logic                           Full,
   output logic                           Empty,
   output logic                           Drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   assign Empty   = (count == '0);
   assign Full    = (count == CNT_W'(DEPTH));
   assign Count   = count;
   assign Rd_Data = mem[rd_ptr];

   // A read frees the slot the write needs, so a full FIFO still accepts
   // data when it is being read in the same cycle.
   assign pop  = Rd_En && !Empty;
   assign push = Wr_En && (!Full || pop);
   assign Drop = Wr_En && Full && !pop;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is reset so the head reads as zero out of reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= Wr_Data;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller: buffers bytes from uart_rx in a FIFO, hands them
// out on a valid/ready port, flags dropped bytes and raises an idle-line
// timeout interrupt when bytes sit unread after the line goes quiet.
//
// Output handshake: a byte transfers on every Clk edge where Out_Valid and
// Out_Ready are both high. Out_Valid never depends combinationally on
// Out_Ready, and Out_Data holds steady while Out_Valid=1 and Out_Ready=0.
//
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   RX_Data     : byte from uart_rx, sampled when RX_Valid is high
//   RX_Valid    : one-cycle "byte complete" pulse from uart_rx
//   Out_Data    : FIFO head (first-word fall-through)
//   Out_Valid   : FIFO non-empty
//   Out_Ready   : consumer accepts Out_Data
//   Count       : entries held
//   Full        : Count == FIFO_DEPTH
//   Overflow    : sticky, a byte was dropped
//   Timeout_Irq : sticky, idle timeout with data pending
//   Clr_Flags   : pulse clearing Overflow and Timeout_Irq (a set wins)
//   Dbg_State   : current timeout FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FREQ_CLK     = 100000000,
   parameter int TX_SPEED     = 115200,
   parameter int FIFO_DEPTH   = 16,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic                              Clk,
   input  logic                              Rst_n,
   input  logic [7:0]                        RX_Data,
   input  logic                              RX_Valid,
   output logic [7:0]                        Out_Data,
   output logic                              Out_Valid,
   input  logic                              Out_Ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   Count,
   output logic                              Full,
   output logic                              Overflow,
   output logic                              Timeout_Irq,
   input  logic                              Clr_Flags,
   output logic [1:0]                        Dbg_State
);

   localparam int unsigned TO_CYCLES =
      timeout_cycles(FREQ_CLK, TX_SPEED, TIMEOUT_BITS);
   localparam int TO_W = $clog2(TO_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   logic              fifo_empty;
   logic              fifo_drop;
   rx_ctrl_state_t    state;
   logic [TO_W-1:0]   to_cnt;
   logic              overflow;
   logic              timeout_irq;

   fifo_sync #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Wr_Data (RX_Data),
      .Wr_En   (RX_Valid),
      .Rd_En   (Out_Ready),
      .Rd_Data (Out_Data),
      .Count   (Count),
      .Full    (Full),
      .Empty   (fifo_empty),
      .Drop    (fifo_drop)
   );

   assign Out_Valid   = !fifo_empty;
   assign Overflow    = overflow;
   assign Timeout_Irq = timeout_irq;
   assign Dbg_State   = state;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         overflow <= 1'b0;
      end else if (fifo_drop) begin
         overflow <= 1'b1;
      end else if (Clr_Flags) begin
         overflow <= 1'b0;
      end
   end

   // Idle timeout. A new byte always restarts the count, even one that was
   // dropped; draining to empty parks the FSM. The empty test uses the
   // pre-edge fill level, so a byte popped on the expiry edge still counts
   // as pending.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         to_cnt      <= '0;
         timeout_irq <= 1'b0;
      end else begin
         // A set below overrides this clear in the same cycle.
         if (Clr_Flags) timeout_irq <= 1'b0;

         unique case (state)
            IDLE: begin
               to_cnt <= '0;
               if (RX_Valid) state <= ARMED;
            end
            ARMED: begin
               if (RX_Valid) begin
                  to_cnt <= '0;
               end else if (fifo_empty) begin
                  state  <= IDLE;
                  to_cnt <= '0;
               end else if (to_cnt == TO_LAST) begin
                  timeout_irq <= 1'b1;
                  state       <= TIMEOUT;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            TIMEOUT: begin
               if (RX_Valid) begin
                  state  <= ARMED;
                  to_cnt <= '0;
               end else if (fifo_empty) begin
                  state  <= IDLE;
                  to_cnt <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               to_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl at default parameters. A queue-based
// reference model follows the DUT edge by edge; a compare process checks all
// outputs every cycle, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   // 100e6 / 115200 = 868 (truncated), 40 bit times -> 34720 clocks.
   localparam longint T = 34720;

   // ---------------- clock / reset ----------------
   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [7:0] RX_Data = '0;
   logic       RX_Valid = 1'b0;
   logic       Out_Ready = 1'b0;
   logic       Clr_Flags = 1'b0;
   logic [7:0] Out_Data;
   logic       Out_Valid;
   logic [4:0] Count;
   logic       Full;
   logic       Overflow;
   logic       Timeout_Irq;
   logic [1:0] Dbg_State;

   always #5 Clk = ~Clk;

   uart_rx_ctrl dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .RX_Data     (RX_Data),
      .RX_Valid    (RX_Valid),
      .Out_Data    (Out_Data),
      .Out_Valid   (Out_Valid),
      .Out_Ready   (Out_Ready),
      .Count       (Count),
      .Full        (Full),
      .Overflow    (Overflow),
      .Timeout_Irq (Timeout_Irq),
      .Clr_Flags   (Clr_Flags),
      .Dbg_State   (Dbg_State)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   logic       m_ovf;
   logic       m_irq;
   longint     cyc;
   longint     last_rx;      // edge index of the most recent RX_Valid, -1 if none
   bit         empty_seen;   // buffer seen empty at an edge since last_rx

   task automatic m_reset();
      exp_q.delete();
      m_ovf      = 1'b0;
      m_irq      = 1'b0;
      cyc        = 0;
      last_rx    = -1;
      empty_seen = 1'b0;
   endtask

   task automatic m_edge();
      int c;
      bit pop, full, drop, irq_set;
      c       = exp_q.size();
      pop     = (c > 0) && Out_Ready;
      full    = (c == DEPTH);
      drop    = RX_Valid && full && !pop;
      irq_set = 1'b0;
      // Interrupt: exactly T edges after the last received byte, with the
      // buffer non-empty at every edge in between.
      if (RX_Valid) begin
         last_rx    = cyc;
         empty_seen = 1'b0;
      end else if (last_rx >= 0) begin
         if (c == 0) empty_seen = 1'b1;
         else if (!empty_seen && (cyc - last_rx == T)) irq_set = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (Clr_Flags) m_ovf = 1'b0;
      if (irq_set) m_irq = 1'b1;
      else if (Clr_Flags) m_irq = 1'b0;
      if (pop) void'(exp_q.pop_front());
      if (RX_Valid && !drop) exp_q.push_back(RX_Data);
      cyc++;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge Clk or negedge Rst_n);
         if (!Rst_n) m_reset();
         else m_edge();
      end
   end

   // ---------------- scoreboard: per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge Clk);
         if (Rst_n === 1'b1) begin
            logic       ev;
            logic [4:0] ec;
            logic       ef;
            logic [7:0] ed;
            bit         ok;
            ev = (exp_q.size() > 0);
            ec = 5'(exp_q.size());
            ef = (exp_q.size() == DEPTH);
            ed = ev ? exp_q[0] : 8'h00;
            ok = (Out_Valid === ev) && (Count === ec) && (Full === ef) &&
                 (Overflow === m_ovf) && (Timeout_Irq === m_irq) &&
                 (!ev || (Out_Data === ed));
            n_tests++;
            if (!ok) begin
               n_fail++;
               $display("FAIL cycle_model t=%0t got v=%b d=%02h cnt=%0d full=%b ovf=%b irq=%b expected v=%b d=%02h cnt=%0d full=%b ovf=%b irq=%b",
                        $time, Out_Valid, Out_Data, Count, Full, Overflow, Timeout_Irq,
                        ev, ed, ec, ef, m_ovf, m_irq);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs for one edge, then settle just after that edge.
   task automatic step(input logic v, input logic [7:0] d,
                       input logic r, input logic c);
      @(negedge Clk);
      RX_Valid  = v;
      RX_Data   = d;
      Out_Ready = r;
      Clr_Flags = c;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic fill16();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
   endtask

   task automatic drain_all();
      for (int i = 0; i < DEPTH + 4; i++) begin
         if (Out_Valid !== 1'b1) break;
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", Out_Valid, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_valid", Out_Valid, 0);
      chk("rst_count", Count, 0);
      chk("rst_full", Full, 0);
      chk("rst_ovf", Overflow, 0);
      chk("rst_irq", Timeout_Irq, 0);
      chk("rst_data", Out_Data, 8'h00);
      @(negedge Clk);
      Rst_n = 1'b1;

      // Single byte: visible one edge after push, gone one edge after pop.
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("one_valid", Out_Valid, 1);
      chk("one_data", Out_Data, 8'hAA);
      chk("one_count", Count, 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("one_pop_count", Count, 0);
      chk("one_pop_valid", Out_Valid, 0);

      // Three bytes, then back-to-back pops.
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0);
      step(1'b1, 8'hCC, 1'b0, 1'b0);
      chk("three_count", Count, 3);
      chk("three_head", Out_Data, 8'hAA);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("three_2nd", Out_Data, 8'h03);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("three_3rd", Out_Data, 8'hCC);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("three_empty", Out_Valid, 0);

      // Fill, then drop a byte.
      fill16();
      chk("fill_full", Full, 1);
      chk("fill_count", Count, 16);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("drop_ovf", Overflow, 1);
      chk("drop_count", Count, 16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drop_drain", Out_Data, i);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drop_drained", Out_Valid, 0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", Overflow, 0);

      // Full with a simultaneous pop: byte accepted, no overflow.
      fill16();
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      chk("fullpop_ovf", Overflow, 0);
      chk("fullpop_count", Count, 16);
      for (int i = 1; i <= DEPTH; i++) begin
         chk("fullpop_drain", Out_Data, (i == DEPTH) ? 8'hFF : i);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Clear in the same cycle as a drop: set wins.
      fill16();
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clr_vs_drop", Overflow, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_after", Overflow, 0);
      drain_all();

      // Idle timeout with one unread byte.
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("to_state_armed", Dbg_State, ARMED);
      idle(int'(T) - 1);
      chk("to_irq_early", Timeout_Irq, 0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_irq_set", Timeout_Irq, 1);
      chk("to_state", Dbg_State, TIMEOUT);
      idle(3);
      chk("to_irq_sticky", Timeout_Irq, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("to_irq_clr", Timeout_Irq, 0);
      chk("to_count_kept", Count, 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("to_popped", Count, 0);

      // Drain before expiry: no interrupt.
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      idle(19999);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(int'(T) - 20000 + 100);
      chk("to_drained_irq", Timeout_Irq, 0);
      chk("to_drained_state", Dbg_State, IDLE);

      // Randomized traffic against the model, alternating drain pressure.
      for (int i = 0; i < 2500; i++) begin
         logic v, r, c;
         v = ($urandom_range(0, 99) < 45);
         r = ((i / 200) % 2 == 1) ? ($urandom_range(0, 99) < 80)
                                  : ($urandom_range(0, 99) < 25);
         c = ($urandom_range(0, 99) < 3);
         step(v, 8'($urandom_range(0, 255)), r, c);
      end
      drain_all();

      // Asynchronous reset with 5 bytes buffered, FSM armed, overflow set.
      fill16();
      step(1'b1, 8'h77, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", Count, 5);
      chk("pre_rst_ovf", Overflow, 1);
      chk("pre_rst_state", Dbg_State, ARMED);
      @(negedge Clk);
      RX_Valid  = 1'b0;
      Out_Ready = 1'b0;
      #2;
      Rst_n = 1'b0;
      #1;
      chk("arst_valid", Out_Valid, 0);
      chk("arst_count", Count, 0);
      chk("arst_full", Full, 0);
      chk("arst_ovf", Overflow, 0);
      chk("arst_irq", Timeout_Irq, 0);
      chk("arst_data", Out_Data, 8'h00);
      chk("arst_state", Dbg_State, IDLE);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      idle(4);
      chk("post_rst_count", Count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
